// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell and a borrow flop, LSB first.
// Operands load on an accepted start; the result is presented in parallel with a done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Data_in_A,
  input  logic [WIDTH-1:0] Data_in_B,
  input  logic             Data_in_Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Data_out_Diff,
  output logic             Data_out_Borrow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_nxt;
  logic             borrow_reg;
  logic [CNT_W-1:0] count;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (count == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Full-subtractor cell on the current LSBs; the new difference bit enters at the MSB end
  always_comb begin
    a_bit      = a_reg[0];
    b_bit      = b_reg[0];
    d_bit      = a_bit ^ b_bit ^ borrow_reg;
    br_nxt     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_reg);
    result_nxt = result_reg >> 1;
    result_nxt[WIDTH-1] = d_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg           <= '0;
      b_reg           <= '0;
      result_reg      <= '0;
      borrow_reg      <= 1'b0;
      count           <= '0;
      Data_out_Diff   <= '0;
      Data_out_Borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg      <= Data_in_A;
            b_reg      <= Data_in_B;
            borrow_reg <= Data_in_Bin;
            count      <= '0;
          end
        end
        SHIFT: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          result_reg <= result_nxt;
          borrow_reg <= br_nxt;
          count      <= count + 1'b1;
        end
        DONE: begin
          Data_out_Diff   <= result_reg;
          Data_out_Borrow <= borrow_reg;
        end
        default: ;
      endcase
    end
  end

  // done is registered so it rises as the outputs update and lasts one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for arithmetic and timing,
// plus a 1-bit instance checked against the full-subtractor truth table.
module tb_serial_subtractor;

  localparam int W     = 8;
  localparam int LIMIT = 40;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  logic         start1;
  logic         a1;
  logic         b1;
  logic         bin1;
  logic         busy1;
  logic         done1;
  logic         diff1;
  logic         borrow1;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .Data_in_A       (a_in),
    .Data_in_B       (b_in),
    .Data_in_Bin     (bin_in),
    .busy            (busy),
    .done            (done),
    .Data_out_Diff   (diff),
    .Data_out_Borrow (borrow)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start1),
    .Data_in_A       (a1),
    .Data_in_B       (b1),
    .Data_in_Bin     (bin1),
    .busy            (busy1),
    .done            (done1),
    .Data_out_Diff   (diff1),
    .Data_out_Borrow (borrow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; afterwards the inputs are scrambled to prove only captured values count
  task automatic apply_stimulus(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic bin_v);
    @(negedge clk);
    a_in   = a_v;
    b_in   = b_v;
    bin_in = bin_v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    a_in   = ~a_v;
    b_in   = ~b_v;
    bin_in = ~bin_v;
  endtask

  task automatic wait_done(input bit narrow, output int cycles);
    cycles = 0;
    while (!(narrow ? done1 : done) && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    bin_in = 1'b0;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    bin1   = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_w8 got busy=%b done=%b diff=%h borrow=%b expected all 0", busy, done, diff, borrow);
    end
    checks++;
    if ({busy1, done1, diff1, borrow1} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_w1 got %b expected 0000", {busy1, done1, diff1, borrow1});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc;
    apply_stimulus(8'd100, 8'd37, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_busy got %b expected 1", busy);
    end
    wait_done(1'b0, cyc);
    checks++;
    if (cyc != W + 1) begin
      failures++;
      $display("[TB] FAIL basic_latency got %0d expected %0d", cyc, W + 1);
    end
    checks++;
    if ({borrow, diff} !== {1'b0, 8'd63}) begin
      failures++;
      $display("[TB] FAIL basic_result got diff=%0d borrow=%b expected diff=63 borrow=0", diff, borrow);
    end
    @(negedge clk);
    checks++;
    if ({done, borrow, diff} !== {1'b0, 1'b0, 8'd63}) begin
      failures++;
      $display("[TB] FAIL basic_hold got done=%b diff=%0d borrow=%b expected done=0 diff=63 borrow=0", done, diff, borrow);
    end
  endtask

  task automatic test_underflow;
    int cyc;
    apply_stimulus(8'd5, 8'd9, 1'b0);
    wait_done(1'b0, cyc);
    checks++;
    if (cyc >= LIMIT || {borrow, diff} !== {1'b1, 8'hFC}) begin
      failures++;
      $display("[TB] FAIL underflow got diff=%h borrow=%b cycles=%0d expected diff=fc borrow=1", diff, borrow, cyc);
    end
  endtask

  task automatic test_extremes;
    int cyc;
    apply_stimulus(8'h00, 8'h00, 1'b1);
    wait_done(1'b0, cyc);
    checks++;
    if (cyc >= LIMIT || {borrow, diff} !== {1'b1, 8'hFF}) begin
      failures++;
      $display("[TB] FAIL zero_minus_bin got diff=%h borrow=%b cycles=%0d expected diff=ff borrow=1", diff, borrow, cyc);
    end
    apply_stimulus(8'hFF, 8'hFF, 1'b0);
    wait_done(1'b0, cyc);
    checks++;
    if (cyc >= LIMIT || {borrow, diff} !== {1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL ff_minus_ff got diff=%h borrow=%b cycles=%0d expected diff=00 borrow=0", diff, borrow, cyc);
    end
  endtask

  task automatic test_ignored_start;
    int       dones;
    logic [W:0] first;
    dones = 0;
    first = '0;
    apply_stimulus(8'd100, 8'd37, 1'b0);
    repeat (2) @(negedge clk);
    a_in   = 8'd1;
    b_in   = 8'd2;
    bin_in = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int i = 0; i < 2 * W + 6; i++) begin
      if (done) begin
        if (dones == 0) first = {borrow, diff};
        dones++;
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("[TB] FAIL ignored_start_count got %0d done pulses expected 1", dones);
    end
    checks++;
    if (first !== {1'b0, 8'd63}) begin
      failures++;
      $display("[TB] FAIL ignored_start_result got %h expected %h", first, {1'b0, 8'd63});
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    int cyc;
    dones = 0;
    apply_stimulus(8'd200, 8'd1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_mid got busy=%b done=%b diff=%h borrow=%b expected all 0", busy, done, diff, borrow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 6; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0 || diff !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_done got dones=%0d diff=%h expected dones=0 diff=00", dones, diff);
    end
    apply_stimulus(8'd50, 8'd20, 1'b1);
    wait_done(1'b0, cyc);
    checks++;
    if (cyc != W + 1 || {borrow, diff} !== {1'b0, 8'd29}) begin
      failures++;
      $display("[TB] FAIL reset_mid_fresh got diff=%0d borrow=%b cycles=%0d expected diff=29 borrow=0 cycles=%0d", diff, borrow, cyc, W + 1);
    end
  endtask

  task automatic test_width1;
    logic [7:0] d_tab;
    logic [7:0] b_tab;
    logic [2:0] v;
    int         cyc;
    // index = {a,b,bin}
    d_tab = 8'b1001_0110;
    b_tab = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      a1     = v[2];
      b1     = v[1];
      bin1   = v[0];
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      a1     = ~v[2];
      b1     = ~v[1];
      bin1   = ~v[0];
      wait_done(1'b1, cyc);
      checks++;
      if (cyc != 2 || {diff1, borrow1} !== {d_tab[i], b_tab[i]}) begin
        failures++;
        $display("[TB] FAIL width1_%b got d=%b bout=%b cycles=%0d expected d=%b bout=%b cycles=2", v, diff1, borrow1, cyc, d_tab[i], b_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         cv;
    logic [W:0]   exp_v;
    int           cyc;
    @(negedge clk);
    av     = W'($urandom);
    bv     = W'($urandom);
    cv     = 1'($urandom);
    a_in   = av;
    b_in   = bv;
    bin_in = cv;
    start  = 1'b1;
    @(negedge clk);
    cyc = 0;
    for (int n = 0; n < 10; n++) begin
      exp_v = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, cv};
      while (!done && cyc < LIMIT) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != ((n == 0) ? W + 1 : W + 2) || {borrow, diff} !== exp_v) begin
        failures++;
        $display("[TB] FAIL b2b_%0d a=%h b=%h bin=%b got diff=%h borrow=%b cycles=%0d expected diff=%h borrow=%b", n, av, bv, cv, diff, borrow, cyc, exp_v[W-1:0], exp_v[W]);
      end
      if (cyc >= LIMIT) break;
      av     = W'($urandom);
      bv     = W'($urandom);
      cv     = 1'($urandom);
      a_in   = av;
      b_in   = bv;
      bin_in = cv;
      @(negedge clk);
      cyc = 1;
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_underflow;
    test_extremes;
    test_ignored_start;
    test_reset_mid;
    test_width1;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
